if_prefetch_unit: RTL and testbench

- Instruction-fetch stage of the 16-bit CPU pipeline.
- Generates sequential PCs and issues requests to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned instructions with their PCs in a small prefetch FIFO, which feeds the decoder over a valid/ready handshake.
- Handles PC redirects from branch resolution: flushes the buffer and discards stale in-flight responses.

---
 rtl/if_prefetch_unit.sv | 156 +++++++++++++++
 tb/tb_if_prefetch_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: sequential PC generation, credit-limited imem requests,
// prefetch FIFO to decode, and redirect flush. Optional counters: IF_PREFETCH_PERF_EN.
module if_prefetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0]  dec_pc
`ifdef IF_PREFETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_dropped
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_E = (CW+1)'(DEPTH);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]      count_q, count_d;
  logic [CW-1:0]      in_flight_q, in_flight_d;
  logic [CW-1:0]      drop_cnt_q, drop_cnt_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];

  logic [CW:0] credit_used;
  logic        accept;
  logic        push;
  logic        pop;
  logic        drop_rsp;

  // Responses still owed to a flushed stream do not hold FIFO credit.
  assign credit_used = {1'b0, count_q} + {1'b0, in_flight_q - drop_cnt_q};

  assign imem_req_valid = rst && !redirect_valid && (credit_used < DEPTH_E)
                          && (in_flight_q < DEPTH_C);
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign drop_rsp = imem_rsp_valid && (redirect_valid || (drop_cnt_q != '0));
  assign push     = imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0);

  assign dec_valid = (count_q != '0);
  assign pop       = dec_valid && dec_ready;
  assign dec_instr = dec_valid ? instr_mem[rd_ptr_q] : '0;
  assign dec_pc    = dec_valid ? pc_mem[rd_ptr_q]    : '0;

  always_comb begin
    pc_d        = pc_q;
    rsp_pc_d    = rsp_pc_q;
    count_d     = count_q;
    in_flight_d = in_flight_q;
    drop_cnt_d  = drop_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (redirect_valid) begin
      pc_d        = redirect_pc;
      rsp_pc_d    = redirect_pc;
      count_d     = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      in_flight_d = in_flight_q - CW'(imem_rsp_valid);
      drop_cnt_d  = in_flight_q - CW'(imem_rsp_valid);
    end else begin
      if (accept) begin
        pc_d = pc_q + ADDR_W'(1);
      end
      in_flight_d = in_flight_q + CW'(accept) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        rsp_pc_d = rsp_pc_q + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      count_q     <= '0;
      in_flight_q <= '0;
      drop_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      pc_q        <= pc_d;
      rsp_pc_q    <= rsp_pc_d;
      count_q     <= count_d;
      in_flight_q <= in_flight_d;
      drop_cnt_q  <= drop_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Entry storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rsp_data;
      pc_mem[wr_ptr_q]    <= rsp_pc_q;
    end
  end

`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_dropped_q, perf_dropped_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + 32'(pop);
    perf_dropped_d = perf_dropped_q + 32'(drop_rsp);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_dropped_q <= perf_dropped_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
`else
  logic unused_drop;
  assign unused_drop = drop_rsp;
`endif

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit with an in-order, fixed-latency memory model.
module tb_if_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [15:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [15:0] dec_instr;
  logic [15:0] dec_pc;
`ifdef IF_PREFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  if_prefetch_unit #(
    .ADDR_W(16), .INSTR_W(16), .DEPTH(4), .RESET_PC(16'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .dec_valid(dec_valid),
    .dec_ready(dec_ready),
    .dec_instr(dec_instr),
    .dec_pc(dec_pc)
`ifdef IF_PREFETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_dropped(perf_dropped)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 1;
  int n_acc = 0;
  int pops;
  logic [15:0] exp_pc;
  logic [15:0] q_addr[$];
  int          q_due[$];

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive the due response, log an accepted request, advance to the next negedge.
  task automatic tick();
    if (q_addr.size() > 0 && q_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mdata(q_addr[0]);
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    if (imem_req_valid && imem_req_ready) begin
      q_addr.push_back(imem_req_addr);
      q_due.push_back(cyc + lat);
      n_acc++;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    q_addr.delete();
    q_due.delete();
    n_acc = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_ready      = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 0);
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_dec_instr", dec_instr, 0);
    chk("rst_dec_pc", dec_pc, 0);
`ifdef IF_PREFETCH_PERF_EN
    chk("rst_perf_fetched", perf_fetched, 0);
    chk("rst_perf_dropped", perf_dropped, 0);
`endif

    // Streaming with 1-cycle memory latency
    rst = 1'b1; imem_req_ready = 1'b1; dec_ready = 1'b1; lat = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t1_req_valid", imem_req_valid, 1);
      chk("t1_req_addr", imem_req_addr, 32'(i));
      tick();
      if (i == 0) begin
        chk("t1_dec_valid_lat", dec_valid, 0);
      end else begin
        chk("t1_dec_valid", dec_valid, 1);
        chk("t1_dec_pc", dec_pc, 32'(i - 1));
        chk("t1_dec_instr", dec_instr, 32'(mdata(16'(i - 1))));
      end
    end

    // Backpressure fills the FIFO, then drains without loss
    do_reset();
    dec_ready = 1'b0; imem_req_ready = 1'b1; lat = 1;
    repeat (8) tick();
    chk("t2_accepted", n_acc, 4);
    #1;
    chk("t2_req_stalled", imem_req_valid, 0);
    chk("t2_dec_valid", dec_valid, 1);
    chk("t2_head_pc", dec_pc, 0);
    dec_ready = 1'b1; exp_pc = 16'h0000; pops = 0;
    for (int i = 0; i < 8; i++) begin
      if (dec_valid) begin
        chk("t2_seq_pc", dec_pc, 32'(exp_pc));
        chk("t2_seq_instr", dec_instr, 32'(mdata(exp_pc)));
        exp_pc = exp_pc + 16'd1;
        pops++;
      end
      tick();
    end
    chk("t2_pops", pops, 8);
    chk("t2_resumed_acc", n_acc, 11);

    // Redirect with 3 requests in flight
    do_reset();
    dec_ready = 1'b1; imem_req_ready = 1'b1; lat = 4;
    repeat (3) tick();
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    #1;
    chk("t3_redir_req_valid", imem_req_valid, 0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t3_new_req_valid", imem_req_valid, 1);
    chk("t3_new_req_addr", imem_req_addr, 32'h0040);
    for (int k = 0; k < 5; k++) begin
      chk("t3_dec_valid_quiet", dec_valid, 0);
      tick();
    end
    chk("t3_first_valid", dec_valid, 1);
    chk("t3_first_pc", dec_pc, 32'h0040);
    chk("t3_first_instr", dec_instr, 32'(mdata(16'h0040)));
`ifdef IF_PREFETCH_PERF_EN
    chk("t3_perf_dropped", perf_dropped, 3);
`endif
    tick();
    chk("t3_second_pc", dec_pc, 32'h0041);
    tick();
    chk("t3_third_pc", dec_pc, 32'h0042);

    // Redirect coinciding with a response and a decode handshake
    do_reset();
    dec_ready = 1'b1; imem_req_ready = 1'b1; lat = 2;
    repeat (3) tick();
    chk("t4_hs_valid", dec_valid, 1);
    chk("t4_hs_pc", dec_pc, 0);
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    #1;
    chk("t4_redir_req_valid", imem_req_valid, 0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t4_new_req_valid", imem_req_valid, 1);
    chk("t4_new_req_addr", imem_req_addr, 32'h0100);
    chk("t4_flushed", dec_valid, 0);
    tick();
    chk("t4_drop_quiet0", dec_valid, 0);
`ifdef IF_PREFETCH_PERF_EN
    chk("t4_perf_dropped", perf_dropped, 2);
    chk("t4_perf_fetched", perf_fetched, 1);
`endif
    tick();
    chk("t4_drop_quiet1", dec_valid, 0);
    tick();
    chk("t4_new_valid", dec_valid, 1);
    chk("t4_new_pc", dec_pc, 32'h0100);
    chk("t4_new_instr", dec_instr, 32'(mdata(16'h0100)));

    // PC wrap from 0xFFFF
    do_reset();
    dec_ready = 1'b1; imem_req_ready = 1'b1; lat = 1;
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t5_addr_ffff", imem_req_addr, 32'hFFFF);
    tick();
    #1;
    chk("t5_addr_wrap", imem_req_addr, 32'h0000);
    tick();
    chk("t5_dec_pc_ffff", dec_pc, 32'hFFFF);
    chk("t5_dec_instr_ffff", dec_instr, 32'(mdata(16'hFFFF)));
    tick();
    chk("t5_dec_pc_wrap", dec_pc, 32'h0000);
    chk("t5_dec_instr_wrap", dec_instr, 32'(mdata(16'h0000)));

    // Reset mid-stream with entries buffered and 2 requests in flight
    do_reset();
    dec_ready = 1'b0; imem_req_ready = 1'b1; lat = 3;
    repeat (5) tick();
    chk("t6_pre_valid", dec_valid, 1);
    chk("t6_pre_pc", dec_pc, 0);
    rst = 1'b0;
    #1;
    chk("t6_rst_dec_valid", dec_valid, 0);
    chk("t6_rst_req_valid", imem_req_valid, 0);
    chk("t6_rst_dec_instr", dec_instr, 0);
    chk("t6_rst_dec_pc", dec_pc, 0);
`ifdef IF_PREFETCH_PERF_EN
    chk("t6_rst_perf_fetched", perf_fetched, 0);
    chk("t6_rst_perf_dropped", perf_dropped, 0);
`endif
    q_addr.delete();
    q_due.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1; dec_ready = 1'b1; lat = 1;
    #1;
    chk("t6_restart_valid", imem_req_valid, 1);
    chk("t6_restart_addr", imem_req_addr, 0);
    tick();
    tick();
    chk("t6_restart_pc0", dec_pc, 0);
    chk("t6_restart_instr0", dec_instr, 32'(mdata(16'h0000)));
    tick();
    chk("t6_restart_pc1", dec_pc, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
